stream_mux_rr: RTL

- Parametrised N-channel, W-bit streaming multiplexer; successor to the fixed 4:1 combinational mux.
- Selects one input channel per transfer, either by explicit select (manual mode) or by a round-robin pointer over valid channels (RR mode).
- Registers the chosen word into a one-entry output stage with valid/ready handshakes on every port.
- Sits between several producer streams and a single consumer, e.g. a shared UART/bus funnel.

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/stream_mux_rr.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and encodings for the stream multiplexer family.
package mux_pkg;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i.
// ptr_i is expected to be below NUM_CH.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic              gnt_any_o
);

    // Scan ptr, ptr+1, ... modulo NUM_CH, which need not be a power of two.
    always_comb begin
        int unsigned cand;
        logic        found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            cand = 32'(ptr_i) + off;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!found && req_i[IDX_W'(cand)]) begin
                found                  = 1'b1;
                gnt_o[IDX_W'(cand)]    = 1'b1;
                gnt_idx_o              = IDX_W'(cand);
            end
        end
        gnt_any_o = found;
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel streaming mux with manual or round-robin selection feeding a
// one-entry registered output stage with valid/ready on every port.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned PAD_W = 1 << SEL_W;

    out_state_e          state_q, state_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_ch_q, out_ch_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NUM_CH-1:0]   rr_gnt_c;
    logic [SEL_W-1:0]    rr_idx_c;
    logic                rr_any_c;

    logic [PAD_W-1:0]    valid_pad_c;
    logic [PAD_W-1:0]    man_pad_c;
    logic [NUM_CH-1:0]   man_gnt_c;

    logic [NUM_CH-1:0]   grant_oh_c;
    logic [SEL_W-1:0]    grant_idx_c;
    logic                grant_any_c;
    logic                load_en_c;
    logic                accept_c;
    logic [DATA_W-1:0]   grant_word_c;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (SEL_W)
    ) u_rr_arbiter (
        .req_i     (in_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (rr_gnt_c),
        .gnt_idx_o (rr_idx_c),
        .gnt_any_o (rr_any_c)
    );

    // Zero-padding in_valid to 2^SEL_W makes an out-of-range sel grant nothing.
    assign valid_pad_c = PAD_W'(in_valid);
    assign man_pad_c   = valid_pad_c & (PAD_W'(1) << sel);
    assign man_gnt_c   = NUM_CH'(man_pad_c);

    assign grant_oh_c  = (mode == MODE_RR) ? rr_gnt_c : man_gnt_c;
    assign grant_idx_c = (mode == MODE_RR) ? rr_idx_c : sel;
    assign grant_any_c = (mode == MODE_RR) ? rr_any_c : (|man_gnt_c);

    assign load_en_c   = (state_q == ST_EMPTY) || out_ready;
    assign accept_c    = load_en_c && grant_any_c;
    assign in_ready    = load_en_c ? grant_oh_c : '0;

    // One-hot word select from the granted channel.
    always_comb begin
        grant_word_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant_oh_c[c]) begin
                grant_word_c = in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for the output stage and the round-robin pointer.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        rr_ptr_d   = rr_ptr_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !accept_c) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept_c) begin
            out_data_d = grant_word_c;
            out_ch_d   = grant_idx_c;
            if (mode == MODE_RR) begin
                rr_ptr_d = (grant_idx_c == SEL_W'(NUM_CH - 1)) ? '0
                                                               : grant_idx_c + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_ch_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
